// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//
// Queues ALU commands in a small FIFO and issues them one at a time to an
// external combinational 4-bit ALU. Each result is captured and presented on
// a valid/ready result port. Commands are processed strictly in the order
// they were accepted.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_a, cmd_b, cmd_op are the payload
//   alu_a, alu_b, alu_op  operands/op driven to the ALU (zero unless issuing)
//   alu_y, alu_carry      combinational ALU result returned to the sequencer
//   res_valid/res_ready   result handshake; res_y, res_carry, res_zero, res_illegal
//   level                 current FIFO occupancy
//   res_count             results delivered since reset (wraps at 256)

module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_a,
    input  logic [3:0]             cmd_b,
    input  logic [2:0]             cmd_op,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [2:0]             alu_op,
    input  logic [3:0]             alu_y,
    input  logic                   alu_carry,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [3:0]             res_y,
    output logic                   res_carry,
    output logic                   res_zero,
    output logic                   res_illegal,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             res_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_t;

    state_t state, state_next;

    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          push;
    logic          pop;
    logic          accept;
    logic [10:0]   head;
    logic          head_illegal;

    // Readiness depends only on occupancy, never on a pop in the same cycle,
    // and is forced low while reset is held so no command slips in.
    assign cmd_ready    = (count < FULL) && rst_n;
    assign push         = cmd_valid && cmd_ready;
    assign pop          = (state == ISSUE);
    assign accept       = (state == HOLD) && res_ready;
    assign head         = mem[rd_ptr];
    assign head_illegal = (head[2:0] > 3'b100);
    assign level        = count;
    assign res_valid    = (state == HOLD);

    // Command storage; entries are {a, b, op}. Contents need no reset since
    // the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op};
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is
    // a power of two; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state. Leaving HOLD also counts a command arriving in that same
    // cycle, so a freshly pushed command issues without a detour via IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    state_next = ((count != '0) || push) ? ISSUE : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The ALU only sees operands during the single ISSUE cycle.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (state == ISSUE) begin
            alu_a  = head[10:7];
            alu_b  = head[6:3];
            alu_op = head[2:0];
        end
    end

    // Result capture at the end of ISSUE. Unsupported ops override whatever
    // the ALU produced with a fixed zero result flagged as illegal.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_y       <= '0;
            res_carry   <= 1'b0;
            res_zero    <= 1'b0;
            res_illegal <= 1'b0;
        end else if (pop) begin
            if (head_illegal) begin
                res_y       <= '0;
                res_carry   <= 1'b0;
                res_zero    <= 1'b1;
                res_illegal <= 1'b1;
            end else begin
                res_y       <= alu_y;
                res_carry   <= alu_carry;
                res_zero    <= (alu_y == 4'd0);
                res_illegal <= 1'b0;
            end
        end
    end

    // Delivered-result counter, wraps 255 -> 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_count <= '0;
        end else if (accept) begin
            res_count <= res_count + 8'd1;
        end
    end

endmodule
